fifo_sized_flags: RTL and testbench
===================================

Name: fifo_sized_flags

Overview:
- Parametrised synchronous FIFO that generalises the 2-entry FIFO to arbitrary depth and width.
- Adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Uses the same ENQ/DEQ/FULL_N/EMPTY_N/CLR handshake, so it drops into existing pipeline stages where more elasticity or back-pressure look-ahead is needed.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of entries (>=2; need not be a power of 2).
- AF_LEVEL, DEPTH-1, ALMOST_FULL asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, ALMOST_EMPTY asserts when count <= AE_LEVEL (0..DEPTH-1).
- GUARDED, 1, 1 = ENQ while full is always an error; 0 = ENQ+DEQ together while full is legal.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- CLR  in  1  synchronous flush, active-high.
- D_IN  in  WIDTH  enqueue data.
- ENQ  in  1  enqueue request.
- FULL_N  out  1  1 = space available.
- DEQ  in  1  dequeue request.
- EMPTY_N  out  1  1 = data available.
- D_OUT  out  WIDTH  head-of-queue data.
- COUNT  out  CW=$clog2(DEPTH+1)  current occupancy.
- ALMOST_FULL  out  1  count >= AF_LEVEL.
- ALMOST_EMPTY  out  1  count <= AE_LEVEL.
- ENQ_ERR  out  1  sticky: illegal enqueue seen.
- DEQ_ERR  out  1  sticky: dequeue on empty seen.

Behaviour:
- State: storage array mem[DEPTH] of WIDTH bits (not reset); rd_ptr, wr_ptr of $clog2(DEPTH) bits; cnt of CW bits; two sticky error flags.
- Reset (RST=1 at clock edge), which takes priority over everything:
  - rd_ptr=wr_ptr=0, cnt=0.
  - FULL_N=1, EMPTY_N=0, COUNT=0, ALMOST_FULL=(AF_LEVEL==0 ? 1 : 0), ALMOST_EMPTY=1.
  - ENQ_ERR=DEQ_ERR=0.
  - Any in-flight ENQ/DEQ in that cycle is discarded.
- CLR (when not in reset):
  - Same pointer, count and flag effect as reset, including clearing both error flags.
  - Overrides ENQ and DEQ in the same cycle.
- Outputs are combinational from registered state only; no input-to-output combinational path:
  - FULL_N = (cnt != DEPTH).
  - EMPTY_N = (cnt != 0).
  - D_OUT = mem[rd_ptr], valid only while EMPTY_N=1; no bypass, so data written at edge N appears on D_OUT after edge N at the earliest.
- Accepted-operation rules:
  - enq_ok = ENQ & (cnt<DEPTH | (!GUARDED & DEQ & cnt==DEPTH)).
  - deq_ok = DEQ & cnt>0.
- Effect of accepted operations:
  - enq_ok: mem[wr_ptr]<=D_IN; wr_ptr advances.
  - deq_ok: rd_ptr advances.
  - Pointer wrap: ptr==DEPTH-1 -> 0 (explicit compare, valid for non-power-of-2 DEPTH).
- Count update: cnt += enq_ok - deq_ok, so simultaneous ENQ+DEQ leaves cnt unchanged.
- Boundary cases:
  - Full, ENQ&DEQ, GUARDED=0: both accepted, cnt stays DEPTH, new data lands in the slot freed by the head.
  - Full, ENQ&DEQ, GUARDED=1: DEQ accepted, ENQ dropped, ENQ_ERR set, cnt becomes DEPTH-1.
  - Full, ENQ only: dropped, ENQ_ERR set, state unchanged.
  - Empty, DEQ (with or without ENQ): DEQ ignored and DEQ_ERR set; a simultaneous ENQ is still accepted.
- Error flags: once set, stay set until RST or CLR.
- Simulation-only: print a warning on each illegal ENQ/DEQ, excluded from synthesis.

Test Plan:
- Reset then idle (DEPTH=4, WIDTH=8): FULL_N=1, EMPTY_N=0, COUNT=0, ALMOST_EMPTY=1, ALMOST_FULL=0, errors 0.
- Fill and wrap:
  - Enqueue 0x11,0x22,0x33,0x44 on consecutive cycles -> COUNT 1,2,3,4; ALMOST_FULL rises at COUNT=3; FULL_N=0 at 4.
  - Dequeue 4 -> D_OUT 0x11,0x22,0x33,0x44 in order, EMPTY_N=0 at end.
  - Repeat 3 times so pointers wrap; order must be preserved.
- Full with simultaneous ENQ+DEQ:
  - GUARDED=0: COUNT stays 4, head 0x11 removed, 0x55 becomes tail.
  - GUARDED=1: COUNT goes to 3, ENQ_ERR=1, 0x55 never appears.
- Empty DEQ with ENQ 0xA5 -> DEQ_ERR=1, COUNT=1, D_OUT=0xA5 next cycle; ERR stays 1 across following legal traffic until CLR.
- CLR with ENQ+DEQ while COUNT=3 -> next cycle COUNT=0, EMPTY_N=0, FULL_N=1, both errors 0; RST asserted mid-burst gives identical result.
- DEPTH=3 (non-power-of-2), random ENQ/DEQ for 1000 cycles against a scoreboard queue -> data order, COUNT and all flags match the model every cycle.

Source files
------------

// File: rtl/fifo_sized_flags.sv
// fifo_sized_flags
//   Parametrised synchronous FIFO with an occupancy count, programmable
//   almost-full/almost-empty flags and sticky enqueue/dequeue error flags.
//   It uses the ENQ/DEQ/FULL_N/EMPTY_N/CLR handshake of the 2-entry FIFO.
//
// Ports
//   CLK          clock; all state changes on the rising edge
//   RST          synchronous active-high reset (highest priority)
//   CLR          synchronous flush; same effect as reset, overrides ENQ/DEQ
//   D_IN         enqueue data
//   ENQ          enqueue request
//   FULL_N       1 = space available
//   DEQ          dequeue request
//   EMPTY_N      1 = data available
//   D_OUT        head-of-queue data, valid while EMPTY_N=1
//   COUNT        current occupancy
//   ALMOST_FULL  COUNT >= AF_LEVEL
//   ALMOST_EMPTY COUNT <= AE_LEVEL
//   ENQ_ERR      sticky: an enqueue was dropped
//   DEQ_ERR      sticky: a dequeue was attempted while empty
module fifo_sized_flags #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 4,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  parameter  int GUARDED  = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             ENQ,
  output logic             FULL_N,
  input  logic             DEQ,
  output logic             EMPTY_N,
  output logic [WIDTH-1:0] D_OUT,
  output logic [CW-1:0]    COUNT,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY,
  output logic             ENQ_ERR,
  output logic             DEQ_ERR
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          enq_err_reg, enq_err_next;
  logic          deq_err_reg, deq_err_next;

  logic is_full, is_empty;
  logic enq_ok, deq_ok;
  logic mem_we;

  // Explicit wrap compare so non-power-of-2 depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    is_full  = (cnt_reg == DEPTH_C);
    is_empty = (cnt_reg == '0);
    // Unguarded FIFOs accept a write into a full queue when the head is
    // leaving in the same cycle.
    enq_ok   = ENQ && (!is_full || ((GUARDED == 0) && DEQ));
    deq_ok   = DEQ && !is_empty;
    mem_we   = enq_ok && !CLR && !RST;
  end

  always_comb begin
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    cnt_next     = cnt_reg;
    enq_err_next = enq_err_reg;
    deq_err_next = deq_err_reg;
    if (CLR) begin
      rd_ptr_next  = '0;
      wr_ptr_next  = '0;
      cnt_next     = '0;
      enq_err_next = 1'b0;
      deq_err_next = 1'b0;
    end else begin
      if (enq_ok) wr_ptr_next = bump(wr_ptr_reg);
      if (deq_ok) rd_ptr_next = bump(rd_ptr_reg);
      case ({enq_ok, deq_ok})
        2'b10:   cnt_next = cnt_reg + CW'(1);
        2'b01:   cnt_next = cnt_reg - CW'(1);
        default: cnt_next = cnt_reg;
      endcase
      if (ENQ && !enq_ok) enq_err_next = 1'b1;
      if (DEQ && !deq_ok) deq_err_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      cnt_reg     <= '0;
      enq_err_reg <= 1'b0;
      deq_err_reg <= 1'b0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      cnt_reg     <= cnt_next;
      enq_err_reg <= enq_err_next;
      deq_err_reg <= deq_err_next;
    end
  end

  // Storage is never reset; only the pointers decide what is valid.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[wr_ptr_reg] <= D_IN;
  end

  // All outputs come from registered state; there is no bypass path.
  assign FULL_N       = !is_full;
  assign EMPTY_N      = !is_empty;
  assign D_OUT        = mem[rd_ptr_reg];
  assign COUNT        = cnt_reg;
  assign ALMOST_FULL  = (cnt_reg >= AF_C);
  assign ALMOST_EMPTY = (cnt_reg <= AE_C);
  assign ENQ_ERR      = enq_err_reg;
  assign DEQ_ERR      = deq_err_reg;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (!RST && !CLR) begin
      if (ENQ && !enq_ok) $warning("fifo_sized_flags: enqueue while full dropped");
      if (DEQ && !deq_ok) $warning("fifo_sized_flags: dequeue while empty ignored");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sized_flags.sv
// Testbench for fifo_sized_flags: three instances (DEPTH=4 unguarded,
// DEPTH=4 guarded, DEPTH=3 guarded) share one stimulus stream and are each
// compared every cycle with a queue-based reference model, plus directed
// checks for the documented boundary cases.
module tb_fifo_sized_flags;

  typedef logic [7:0] q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1, clr = 1'b0, enq = 1'b0, deq = 1'b0;
  logic [7:0] din = 8'h00;

  always #5 clk = ~clk;

  // Instance 0: DEPTH=4, GUARDED=0
  logic       fn0, en0, af0, ae0, ee0, de0;
  logic [7:0] do0;
  logic [2:0] c0;
  // Instance 1: DEPTH=4, GUARDED=1
  logic       fn1, en1, af1, ae1, ee1, de1;
  logic [7:0] do1;
  logic [2:0] c1;
  // Instance 2: DEPTH=3, GUARDED=1
  logic       fn2, en2, af2, ae2, ee2, de2;
  logic [7:0] do2;
  logic [1:0] c2;

  fifo_sized_flags #(.WIDTH(8), .DEPTH(4), .GUARDED(0)) u_g0 (
    .CLK(clk), .RST(rst), .CLR(clr), .D_IN(din), .ENQ(enq), .FULL_N(fn0),
    .DEQ(deq), .EMPTY_N(en0), .D_OUT(do0), .COUNT(c0), .ALMOST_FULL(af0),
    .ALMOST_EMPTY(ae0), .ENQ_ERR(ee0), .DEQ_ERR(de0));

  fifo_sized_flags #(.WIDTH(8), .DEPTH(4), .GUARDED(1)) u_g1 (
    .CLK(clk), .RST(rst), .CLR(clr), .D_IN(din), .ENQ(enq), .FULL_N(fn1),
    .DEQ(deq), .EMPTY_N(en1), .D_OUT(do1), .COUNT(c1), .ALMOST_FULL(af1),
    .ALMOST_EMPTY(ae1), .ENQ_ERR(ee1), .DEQ_ERR(de1));

  fifo_sized_flags #(.WIDTH(8), .DEPTH(3), .GUARDED(1)) u_d3 (
    .CLK(clk), .RST(rst), .CLR(clr), .D_IN(din), .ENQ(enq), .FULL_N(fn2),
    .DEQ(deq), .EMPTY_N(en2), .D_OUT(do2), .COUNT(c2), .ALMOST_FULL(af2),
    .ALMOST_EMPTY(ae2), .ENQ_ERR(ee2), .DEQ_ERR(de2));

  // Reference model state
  q_t q0, q1, q2;
  bit m_ee0, m_de0, m_ee1, m_de1, m_ee2, m_de2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue semantics: an enqueue is accepted if there is room, or (unguarded
  // only) if the queue is full and the head leaves in the same cycle.
  task automatic model_step(inout q_t q, inout bit ee, inout bit de,
                            input int depth, input bit guarded);
    int  n;
    bit  enq_acc, deq_acc;
    if (rst || clr) begin
      q.delete();
      ee = 1'b0;
      de = 1'b0;
    end else begin
      n       = q.size();
      enq_acc = enq && (n < depth || (!guarded && deq && n == depth));
      deq_acc = deq && n > 0;
      if (enq && !enq_acc) ee = 1'b1;
      if (deq && n == 0)   de = 1'b1;
      if (deq_acc) void'(q.pop_front());
      if (enq_acc) q.push_back(din);
    end
  endtask

  task automatic check_dut(input string nm, input q_t q, input bit ee, input bit de,
                           input int depth, input logic [2:0] cnt, input logic fn,
                           input logic en, input logic af, input logic ae,
                           input logic ge, input logic gd, input logic [7:0] dout);
    int n;
    n = q.size();
    check_val({nm, ".count"},   32'(cnt), 32'(n));
    check_val({nm, ".full_n"},  32'(fn),  32'(n != depth));
    check_val({nm, ".empty_n"}, 32'(en),  32'(n != 0));
    check_val({nm, ".afull"},   32'(af),  32'(n >= depth - 1));
    check_val({nm, ".aempty"},  32'(ae),  32'(n <= 1));
    check_val({nm, ".enq_err"}, 32'(ge),  32'(ee));
    check_val({nm, ".deq_err"}, 32'(gd),  32'(de));
    if (n > 0) check_val({nm, ".d_out"}, 32'(dout), 32'(q[0]));
  endtask

  task automatic cycle(input bit r, input bit c, input bit e, input bit d, input logic [7:0] di);
    rst = r; clr = c; enq = e; deq = d; din = di;
    @(posedge clk);
    model_step(q0, m_ee0, m_de0, 4, 1'b0);
    model_step(q1, m_ee1, m_de1, 4, 1'b1);
    model_step(q2, m_ee2, m_de2, 3, 1'b1);
    @(negedge clk);
    check_dut("g0", q0, m_ee0, m_de0, 4, c0, fn0, en0, af0, ae0, ee0, de0, do0);
    check_dut("g1", q1, m_ee1, m_de1, 4, c1, fn1, en1, af1, ae1, ee1, de1, do1);
    check_dut("d3", q2, m_ee2, m_de2, 3, {1'b0, c2}, fn2, en2, af2, ae2, ee2, de2, do2);
    $display("cyc rst=%0b clr=%0b enq=%0b deq=%0b din=%02h | cnt %0d/%0d/%0d",
             r, c, e, d, di, c0, c1, c2);
  endtask

  initial begin
    logic [7:0] fill_vals [4];
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;

    // Reset then idle
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    check_val("rst.full_n", 32'(fn0), 32'd1);
    check_val("rst.empty_n", 32'(en0), 32'd0);
    check_val("rst.count", 32'(c0), 32'd0);
    check_val("rst.aempty", 32'(ae0), 32'd1);
    check_val("rst.afull", 32'(af0), 32'd0);

    // Fill and drain three times so both pointers wrap
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 4; i++) begin
        cycle(0, 0, 1, 0, fill_vals[i]);
        check_val("fill.count", 32'(c0), 32'(i + 1));
        check_val("fill.afull", 32'(af0), 32'(i >= 2));
      end
      check_val("fill.full_n", 32'(fn0), 32'd0);
      for (int i = 0; i < 4; i++) begin
        check_val("drain.d_out", 32'(do0), 32'(fill_vals[i]));
        cycle(0, 0, 0, 1, 8'h00);
      end
      check_val("drain.empty_n", 32'(en0), 32'd0);
    end

    // Full with simultaneous ENQ+DEQ
    cycle(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, fill_vals[i]);
    cycle(0, 0, 1, 1, 8'h55);
    check_val("full.g0.count", 32'(c0), 32'd4);
    check_val("full.g0.head", 32'(do0), 32'h22);
    check_val("full.g0.enq_err", 32'(ee0), 32'd0);
    check_val("full.g1.count", 32'(c1), 32'd3);
    check_val("full.g1.enq_err", 32'(ee1), 32'd1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 8'h00);

    // Dequeue on empty with a simultaneous enqueue
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 0, 1, 1, 8'hA5);
    check_val("edeq.deq_err", 32'(de1), 32'd1);
    check_val("edeq.count", 32'(c1), 32'd1);
    check_val("edeq.d_out", 32'(do1), 32'hA5);
    cycle(0, 0, 1, 0, 8'h01);
    cycle(0, 0, 0, 1, 8'h00);
    cycle(0, 0, 1, 0, 8'h02);
    cycle(0, 0, 1, 0, 8'h03);
    check_val("edeq.sticky", 32'(de1), 32'd1);
    check_val("edeq.count3", 32'(c1), 32'd3);

    // CLR with ENQ+DEQ at COUNT=3
    cycle(0, 1, 1, 1, 8'h77);
    check_val("clr.count", 32'(c1), 32'd0);
    check_val("clr.empty_n", 32'(en1), 32'd0);
    check_val("clr.full_n", 32'(fn1), 32'd1);
    check_val("clr.deq_err", 32'(de1), 32'd0);
    check_val("clr.enq_err", 32'(ee1), 32'd0);

    // RST mid-burst gives the same result
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, fill_vals[i]);
    cycle(0, 0, 1, 1, 8'h99);
    cycle(1, 0, 1, 1, 8'h88);
    check_val("rstb.count", 32'(c0), 32'd0);
    check_val("rstb.empty_n", 32'(en0), 32'd0);
    check_val("rstb.full_n", 32'(fn0), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 1000; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
            $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
            8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
